// File: rtl/apb_master_bridge_if.sv
// CPU-side request/response and APB bus signals of the bridge, one bundle.
// transfer is a request strobe taken only while the bridge is idle; ready is a one-cycle completion pulse, and err qualifies it.
interface apb_master_bridge_if;
  logic        transfer;
  logic        write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic [31:0] PADDR;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic        PENABLE;
  logic [3:0]  PSEL;
  logic [31:0] PRDATA0;
  logic [31:0] PRDATA1;
  logic [31:0] PRDATA2;
  logic [31:0] PRDATA3;
  logic [3:0]  PREADY;

  modport master (
    input  transfer, write, addr, wdata, PRDATA0, PRDATA1, PRDATA2, PRDATA3, PREADY,
    output rdata, ready, err, PADDR, PWRITE, PWDATA, PENABLE, PSEL
  );

  modport slave (
    output transfer, write, addr, wdata, PRDATA0, PRDATA1, PRDATA2, PRDATA3, PREADY,
    input  rdata, ready, err, PADDR, PWRITE, PWDATA, PENABLE, PSEL
  );
endinterface

// File: rtl/apb_master_bridge.sv
// APB master: decodes a CPU request to one of four slots, runs SETUP/ACCESS,
// and returns read data with a completion pulse, or an error on bad decode/timeout.
module apb_master_bridge #(
  parameter int unsigned TIMEOUT = 16,
  parameter logic [15:0] BASE_HI = 16'h1000
) (
  input  logic                       PCLK,
  input  logic                       PRESET,
  apb_master_bridge_if.master        bus,
  output logic [2:0]                 dbg_state
);
  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, DONE, ERR} state_t;

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t         state;
  logic [1:0]     idx;
  logic [CW-1:0]  tmo_cnt;
  logic           addr_ok;
  logic           sel_ready;
  logic [31:0]    sel_rdata;

  assign addr_ok = (bus.addr[31:16] == BASE_HI) && (bus.addr[15:14] == 2'b00);

  // Only the selected slot's PREADY/PRDATA matter; the others are ignored.
  always_comb begin
    sel_ready = bus.PREADY[idx];
    case (idx)
      2'd0:    sel_rdata = bus.PRDATA0;
      2'd1:    sel_rdata = bus.PRDATA1;
      2'd2:    sel_rdata = bus.PRDATA2;
      default: sel_rdata = bus.PRDATA3;
    endcase
  end

  assign bus.PSEL    = (state == SETUP || state == ACCESS) ? (4'b0001 << idx) : 4'b0000;
  assign bus.PENABLE = (state == ACCESS);
  assign dbg_state   = state;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state      <= IDLE;
      idx        <= 2'd0;
      tmo_cnt    <= '0;
      bus.PADDR  <= 32'd0;
      bus.PWDATA <= 32'd0;
      bus.PWRITE <= 1'b0;
      bus.rdata  <= 32'd0;
      bus.ready  <= 1'b0;
      bus.err    <= 1'b0;
    end else begin
      bus.ready <= 1'b0;
      bus.err   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.transfer) begin
            bus.PADDR  <= bus.addr;
            bus.PWDATA <= bus.wdata;
            bus.PWRITE <= bus.write;
            idx        <= bus.addr[13:12];
            if (addr_ok) begin
              state <= SETUP;
            end else begin
              state     <= ERR;
              bus.ready <= 1'b1;
              bus.err   <= 1'b1;
              bus.rdata <= 32'd0;
            end
          end
        end
        SETUP: begin
          state   <= ACCESS;
          tmo_cnt <= '0;
        end
        ACCESS: begin
          // A PREADY arriving in the last allowed cycle wins over the timeout.
          if (sel_ready) begin
            state     <= DONE;
            bus.ready <= 1'b1;
            bus.rdata <= bus.PWRITE ? 32'd0 : sel_rdata;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (tmo_cnt == CW'(TIMEOUT - 1)) begin
              state     <= ERR;
              bus.ready <= 1'b1;
              bus.err   <= 1'b1;
              bus.rdata <= 32'd0;
            end
          end
        end
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: directed protocol cases then randomized transfers
// checked against a latency/result model of the bridge.
module tb_apb_master_bridge;
  localparam int TIMEOUT = 16;

  logic       PCLK = 1'b0;
  logic       PRESET;
  logic [2:0] dbg_state;

  apb_master_bridge_if bus ();

  apb_master_bridge #(.TIMEOUT(TIMEOUT), .BASE_HI(16'h1000)) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 PCLK = ~PCLK;

  // ---------------- slave models ----------------
  // Slot i raises PREADY on its (slave_wait[i]+1)-th ACCESS cycle; 255 never answers.
  logic [7:0]  slave_wait [4];
  logic [31:0] slave_data [4];
  logic [3:0]  force_hi;
  logic [7:0]  acc_cnt [4];
  logic [3:0]  pready_v;

  always @(posedge PCLK or posedge PRESET) begin
    for (int i = 0; i < 4; i++) begin
      if (PRESET) acc_cnt[i] <= 8'd0;
      else if (bus.PSEL[i] && bus.PENABLE) acc_cnt[i] <= acc_cnt[i] + 8'd1;
      else acc_cnt[i] <= 8'd0;
    end
  end

  always_comb begin
    pready_v = force_hi;
    for (int i = 0; i < 4; i++)
      if (bus.PSEL[i] && bus.PENABLE && acc_cnt[i] == slave_wait[i]) pready_v[i] = 1'b1;
  end

  assign bus.PREADY  = pready_v;
  assign bus.PRDATA0 = slave_data[0];
  assign bus.PRDATA1 = slave_data[1];
  assign bus.PRDATA2 = slave_data[2];
  assign bus.PRDATA3 = slave_data[3];

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input string field, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s/%s: observed %0h expected %0h", tag, field, obs, exp);
    end
  endtask

  // Reference: cycles from accept to ready, err flag, rdata and the select pattern.
  function automatic void predict(input logic wr, input logic [31:0] a, output int lat,
                                  output logic e, output logic [31:0] rd, output logic [3:0] ps);
    int i;
    int w;
    ps = 4'b0000;
    if (a[31:16] != 16'h1000 || a[15:14] != 2'b00) begin
      lat = 1; e = 1'b1; rd = 32'd0;
      return;
    end
    i = int'(a[13:12]);
    ps[i] = 1'b1;
    w = force_hi[i] ? 0 : int'(slave_wait[i]);
    if (w >= TIMEOUT) begin
      lat = 2 + TIMEOUT; e = 1'b1; rd = 32'd0;
    end else begin
      lat = 3 + w; e = 1'b0; rd = wr ? 32'd0 : slave_data[i];
    end
  endfunction

  // ---------------- driver ----------------
  // mode 0: drop transfer after accept; 1: keep it high; 2: random noise on request inputs while busy.
  task automatic do_xfer(input logic wr, input logic [31:0] a, input logic [31:0] wd, input int mode, input string tag);
    int          lat;
    logic        e;
    logic [31:0] rd;
    logic [3:0]  ps;
    predict(wr, a, lat, e, rd, ps);
    @(negedge PCLK);
    bus.transfer = 1'b1;
    bus.write    = wr;
    bus.addr     = a;
    bus.wdata    = wd;
    for (int n = 1; n <= lat; n++) begin
      @(negedge PCLK);
      if (n < lat) begin
        check(tag, "ready_busy", 32'(bus.ready), 32'd0);
        check(tag, "err_busy", 32'(bus.err), 32'd0);
        check(tag, "psel", 32'(bus.PSEL), 32'(ps));
        check(tag, "penable", 32'(bus.PENABLE), (n >= 2) ? 32'd1 : 32'd0);
      end else begin
        check(tag, "ready", 32'(bus.ready), 32'd1);
        check(tag, "err", 32'(bus.err), 32'(e));
        check(tag, "rdata", bus.rdata, rd);
        check(tag, "psel_end", 32'(bus.PSEL), 32'd0);
        check(tag, "penable_end", 32'(bus.PENABLE), 32'd0);
      end
      check(tag, "paddr", bus.PADDR, a);
      check(tag, "pwdata", bus.PWDATA, wd);
      check(tag, "pwrite", 32'(bus.PWRITE), 32'(wr));
      if (mode == 0) begin
        bus.transfer = 1'b0;
      end else if (mode == 2) begin
        bus.transfer = 1'($urandom_range(0, 1));
        bus.addr     = $urandom;
        bus.wdata    = $urandom;
        bus.write    = 1'($urandom_range(0, 1));
      end
    end
    if (mode == 2) bus.transfer = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0]  wait_tab [8];
    logic [31:0] a;
    logic [15:0] hi;
    int          kind;

    wait_tab[0] = 8'd0;  wait_tab[1] = 8'd0;  wait_tab[2] = 8'd1;  wait_tab[3] = 8'd2;
    wait_tab[4] = 8'd5;  wait_tab[5] = 8'd15; wait_tab[6] = 8'd16; wait_tab[7] = 8'd255;

    PRESET       = 1'b1;
    bus.transfer = 1'b0;
    bus.write    = 1'b0;
    bus.addr     = 32'd0;
    bus.wdata    = 32'd0;
    force_hi     = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      slave_wait[i] = 8'd0;
      slave_data[i] = 32'h5A5A_0000 + 32'(i);
    end

    repeat (3) @(negedge PCLK);
    check("reset", "psel", 32'(bus.PSEL), 32'd0);
    check("reset", "penable", 32'(bus.PENABLE), 32'd0);
    check("reset", "pwrite", 32'(bus.PWRITE), 32'd0);
    check("reset", "paddr", bus.PADDR, 32'd0);
    check("reset", "pwdata", bus.PWDATA, 32'd0);
    check("reset", "rdata", bus.rdata, 32'd0);
    check("reset", "ready", 32'(bus.ready), 32'd0);
    check("reset", "err", 32'(bus.err), 32'd0);
    PRESET = 1'b0;

    // Zero-wait read from slot 1
    slave_data[1] = 32'hCAFE_0001;
    do_xfer(1'b0, 32'h1000_1004, 32'h1111_2222, 0, "zw_read");

    // Registered-ready slot 0: read then write
    slave_wait[0] = 8'd1;
    slave_data[0] = 32'h0000_00A5;
    do_xfer(1'b0, 32'h1000_0004, 32'h0, 0, "gpi_read");
    do_xfer(1'b1, 32'h1000_0000, 32'h0000_00FF, 0, "gpo_write");

    // Decode errors
    do_xfer(1'b0, 32'h2000_0000, 32'h0, 0, "dec_hi");
    do_xfer(1'b1, 32'h1000_4000, 32'h77, 0, "dec_mid");

    // Timeout and the boundary where PREADY arrives on the last allowed cycle
    slave_wait[3] = 8'd255;
    do_xfer(1'b0, 32'h1000_3000, 32'h0, 0, "timeout");
    slave_wait[3] = 8'd15;
    slave_data[3] = 32'h3333_0F0F;
    do_xfer(1'b0, 32'h1000_3000, 32'h0, 0, "late_ready");
    slave_wait[3] = 8'd16;
    do_xfer(1'b1, 32'h1000_3ABC, 32'hDEAD_BEEF, 0, "just_late");

    // Foreign PREADY must not complete the transfer; request noise while busy
    force_hi      = 4'b0100;
    slave_wait[0] = 8'd3;
    slave_data[2] = 32'hBAD0_BAD0;
    do_xfer(1'b0, 32'h1000_0008, 32'h0, 2, "busy_noise");
    force_hi = 4'b0000;

    // Back-to-back with transfer held high
    slave_wait[1] = 8'd0;
    slave_wait[2] = 8'd2;
    do_xfer(1'b0, 32'h1000_1010, 32'h0, 1, "b2b_0");
    do_xfer(1'b1, 32'h1000_2020, 32'hAAAA_5555, 1, "b2b_1");
    do_xfer(1'b0, 32'h1000_2024, 32'h0, 0, "b2b_2");

    // Reset in the middle of ACCESS
    slave_wait[3] = 8'd255;
    @(negedge PCLK);
    bus.transfer = 1'b1; bus.write = 1'b0; bus.addr = 32'h1000_3010; bus.wdata = 32'h0;
    @(negedge PCLK);
    bus.transfer = 1'b0;
    repeat (2) @(negedge PCLK);
    check("rst_mid", "penable_pre", 32'(bus.PENABLE), 32'd1);
    check("rst_mid", "psel_pre", 32'(bus.PSEL), 32'h8);
    #2 PRESET = 1'b1;
    #1;
    check("rst_mid", "psel", 32'(bus.PSEL), 32'd0);
    check("rst_mid", "penable", 32'(bus.PENABLE), 32'd0);
    check("rst_mid", "ready", 32'(bus.ready), 32'd0);
    check("rst_mid", "paddr", bus.PADDR, 32'd0);
    @(negedge PCLK);
    PRESET = 1'b0;
    repeat (3) begin
      @(negedge PCLK);
      check("rst_after", "ready", 32'(bus.ready), 32'd0);
      check("rst_after", "psel", 32'(bus.PSEL), 32'd0);
    end
    slave_data[1] = 32'h0123_4567;
    do_xfer(1'b0, 32'h1000_1000, 32'h0, 0, "rst_fresh");

    // Randomized transfers
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 4; i++) begin
        slave_wait[i] = wait_tab[$urandom_range(0, 7)];
        slave_data[i] = $urandom;
      end
      force_hi = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      kind = int'($urandom_range(0, 7));
      if (kind == 0) begin
        hi = 16'($urandom);
        if (hi == 16'h1000) hi = 16'h1001;
        a = {hi, 16'($urandom)};
      end else if (kind == 1) begin
        a = {16'h1000, 2'($urandom_range(1, 3)), 14'($urandom)};
      end else begin
        a = {16'h1000, 2'b00, 2'($urandom_range(0, 3)), 12'($urandom)};
      end
      do_xfer(1'($urandom_range(0, 1)), a, $urandom, int'($urandom_range(0, 2)), "rand");
    end
    bus.transfer = 1'b0;

    repeat (2) @(negedge PCLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
